// File: rtl/axil_reg_slave_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axil_reg_pkg;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Word index from a byte address, keeping only the low aw address bits.
   function automatic int unsigned addr_to_idx(input logic [31:0] addr, input int unsigned aw);
      logic [31:0] mask;
      mask = (32'd1 << aw) - 32'd1;
      return (addr & mask) >> 2;
   endfunction

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave (32-bit data).
interface axil_reg_slave_if #(
   parameter int ADDR_WIDTH = 5
) ();
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic [2:0]            AWPROT;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [31:0]           WDATA;
   logic [3:0]            WSTRB;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [2:0]            ARPROT;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [31:0]           RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axil_reg_slave_wstrb_merge.sv
// Byte-strobe merge: strobed bytes come from wdata, the rest from old.
module axil_wstrb_merge #(
   parameter int NBYTES = 4
) (
   input  logic [8*NBYTES-1:0] i_old,
   input  logic [8*NBYTES-1:0] i_wdata,
   input  logic [NBYTES-1:0]   i_wstrb,
   output logic [8*NBYTES-1:0] o_new
);
   for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      assign o_new[8*b +: 8] = i_wstrb[b] ? i_wdata[8*b +: 8] : i_old[8*b +: 8];
   end
endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with NUM_REGS R/W registers and independent write/read FSMs.
// Define AXIL_REG_SLAVE_WR_COUNT_EN to expose a read-only OKAY-write counter at index NUM_REGS.
module axil_reg_slave
   import axil_reg_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 4
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   axil_reg_slave_if.slave          s_axil,
   output logic [32*NUM_REGS-1:0]   REGS_OUT
);

   logic [NUM_REGS-1:0][31:0] r_regs;
   logic [31:0]               w_merged [NUM_REGS];

   wstate_t r_wstate, w_wstate_nxt;
   rstate_t r_rstate, w_rstate_nxt;

   logic                  r_aw_got, r_w_got;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic [1:0]            r_bresp, r_rresp;
   logic [31:0]           r_rdata;

   logic                  w_aw_hs, w_w_hs, w_commit, w_b_hs, w_ar_hs;
   logic [ADDR_WIDTH-1:0] w_awaddr;
   logic [31:0]           w_wdata;
   logic [3:0]            w_wstrb;
   int unsigned           w_widx, w_ridx;
   logic                  w_wr_ok, w_rd_ok;
   logic [31:0]           w_rd_val;

   logic w_unused;
   assign w_unused = ^{s_axil.AWPROT, s_axil.ARPROT, DATA_WIDTH[0]};

   // ---------------- write channel ----------------
   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) r_wstate <= W_IDLE;
      else        r_wstate <= w_wstate_nxt;

   always_comb begin
      w_wstate_nxt   = r_wstate;
      s_axil.AWREADY = 1'b0;
      s_axil.WREADY  = 1'b0;
      s_axil.BVALID  = 1'b0;
      w_aw_hs        = 1'b0;
      w_w_hs         = 1'b0;
      w_b_hs         = 1'b0;
      w_commit       = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            s_axil.AWREADY = !r_aw_got;
            s_axil.WREADY  = !r_w_got;
            w_aw_hs        = s_axil.AWVALID && !r_aw_got;
            w_w_hs         = s_axil.WVALID && !r_w_got;
            if ((w_aw_hs || r_aw_got) && (w_w_hs || r_w_got)) begin
               w_commit     = 1'b1;
               w_wstate_nxt = W_RESP;
            end
         end
         W_RESP: begin
            s_axil.BVALID = 1'b1;
            w_b_hs        = s_axil.BREADY;
            if (s_axil.BREADY) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   // A channel handshaking on the commit edge is used directly, not via its latch.
   assign w_awaddr = w_aw_hs ? s_axil.AWADDR : r_awaddr;
   assign w_wdata  = w_w_hs  ? s_axil.WDATA  : r_wdata;
   assign w_wstrb  = w_w_hs  ? s_axil.WSTRB  : r_wstrb;
   assign w_widx   = addr_to_idx(32'(w_awaddr), ADDR_WIDTH);
   assign w_wr_ok  = (w_widx < NUM_REGS);

   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (w_aw_hs) begin
            r_aw_got <= 1'b1;
            r_awaddr <= s_axil.AWADDR;
         end
         if (w_w_hs) begin
            r_w_got <= 1'b1;
            r_wdata <= s_axil.WDATA;
            r_wstrb <= s_axil.WSTRB;
         end
      end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      axil_wstrb_merge #(.NBYTES(4)) u_merge (
         .i_old   (r_regs[i]),
         .i_wdata (w_wdata),
         .i_wstrb (w_wstrb),
         .o_new   (w_merged[i])
      );
   end

   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) r_regs <= '0;
      else if (w_commit && w_wr_ok)
         for (int i = 0; i < NUM_REGS; i++)
            if (w_widx == 32'(i)) r_regs[i] <= w_merged[i];

   assign s_axil.BRESP = r_bresp;
   assign REGS_OUT     = r_regs;

`ifdef AXIL_REG_SLAVE_WR_COUNT_EN
   logic [31:0] r_wr_cnt;
   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET)                             r_wr_cnt <= '0;
      else if (w_b_hs && r_bresp == RESP_OKAY) r_wr_cnt <= r_wr_cnt + 32'd1;
`endif

   // ---------------- read channel ----------------
   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) r_rstate <= R_IDLE;
      else        r_rstate <= w_rstate_nxt;

   always_comb begin
      w_rstate_nxt   = r_rstate;
      s_axil.ARREADY = 1'b0;
      s_axil.RVALID  = 1'b0;
      w_ar_hs        = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            s_axil.ARREADY = 1'b1;
            w_ar_hs        = s_axil.ARVALID;
            if (s_axil.ARVALID) w_rstate_nxt = R_DATA;
         end
         R_DATA: begin
            s_axil.RVALID = 1'b1;
            if (s_axil.RREADY) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   assign w_ridx = addr_to_idx(32'(s_axil.ARADDR), ADDR_WIDTH);

   // Reads see r_regs before any same-edge commit, i.e. the pre-write value.
   always_comb begin
      w_rd_val = '0;
      w_rd_ok  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         if (w_ridx == 32'(i)) begin
            w_rd_val = r_regs[i];
            w_rd_ok  = 1'b1;
         end
`ifdef AXIL_REG_SLAVE_WR_COUNT_EN
      if (w_ridx == 32'(NUM_REGS)) begin
         w_rd_val = r_wr_cnt;
         w_rd_ok  = 1'b1;
      end
`endif
   end

   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_val;
         r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end

   assign s_axil.RDATA = r_rdata;
   assign s_axil.RRESP = r_rresp;

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder holding NUM_REGS 32-bit read/write registers.
- It is the slave end that the AXI VIP master in the block-design test bench drives with AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST.
- Independent write and read channel FSMs, byte strobes, and SLVERR on out-of-range addresses.
- Register contents are also exported as a flat vector for user logic.

Parameters:
- DATA_WIDTH, 32, AXI data width; fixed at 32, other values unsupported.
- ADDR_WIDTH, 5, byte-address width; register index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of R/W registers; must satisfy NUM_REGS < 2**(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1
- AWREADY  out  1
- WDATA  in  32
- WSTRB  in  4  byte enables.
- WVALID  in  1
- WREADY  out  1
- BRESP  out  2  OKAY=2'b00, SLVERR=2'b10.
- BVALID  out  1
- BREADY  in  1
- ARADDR  in  ADDR_WIDTH
- ARPROT  in  3  ignored.
- ARVALID  in  1
- ARREADY  out  1
- RDATA  out  32
- RRESP  out  2
- RVALID  out  1
- RREADY  in  1
- REGS_OUT  out  32*NUM_REGS  register i at bits [32*i+31:32*i].

Behaviour:
- Reset (async assert, sync-released use):
  - All registers = 0.
  - AWREADY = WREADY = ARREADY = 1.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0.
  - Both FSMs go to IDLE. Any in-flight transaction is dropped with no response.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AWREADY=1 until AW is latched; WREADY=1 until W is latched.
  - AW and W are accepted in either order or in the same cycle; the latched channel deasserts its READY.
  - On the edge where the second of AW/W handshakes (or both together), the write commits: bytes with WSTRB[k]=1 are updated, others kept. The FSM moves to W_RESP.
  - W_RESP: BVALID=1 from the next cycle, i.e. latency of 1 cycle after the final handshake. AWREADY=WREADY=0.
  - BVALID and BRESP are held stable until BREADY. On the BVALID&BREADY edge: BVALID=0, AWREADY=WREADY=1, back to W_IDLE.
  - Index >= NUM_REGS (and not the counter slot): no register changes, BRESP=SLVERR.
  - WSTRB=0: no change, BRESP=OKAY.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On handshake, RDATA/RRESP are loaded at that edge, RVALID=1 next cycle, ARREADY=0.
  - RDATA/RRESP are held stable until RREADY. On the handshake edge: RVALID=0, ARREADY=1.
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
- Simultaneous events:
  - A read sampled on the same edge as a write commit to the same register returns the pre-write value.
  - The read and write channels never stall each other.
- No outstanding-transaction pipelining: at most one write and one read in flight.
- REGS_OUT reflects the committed value from the cycle after commit.

Optional Feature:
- Macro AXIL_REG_SLAVE_WR_COUNT_EN.
- Defined:
  - Register index NUM_REGS is a read-only 32-bit count of completed write responses with BRESP=OKAY, counted on the B handshake edge.
  - The count wraps at 2**32 and resets to 0.
  - Writes to this index are ignored and answered with SLVERR.
  - Reads return the count with RRESP=OKAY.
- Undefined:
  - Index NUM_REGS is out of range like any other; no counter flops are present.

Decomposition:
- Package axil_reg_pkg holds:
  - typedefs for the write and read state enums;
  - RESP_OKAY / RESP_SLVERR constants;
  - an addr-to-index function.
- One natural sub-module, axil_wstrb_merge: combinational byte merge (old, wdata, wstrb) -> new. The FSMs stay in the top module.

Test Plan:
- Sequential regs: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read the same addresses -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY, REGS_OUT matches.
- Strobe: reg0=0x00000001, then write 0xAABBCCDD with WSTRB=4'b0010 -> read 0x0 returns 0x0000CC01.
- Ordering:
  - W valid 3 cycles before AW -> WREADY drops after the W handshake, BVALID comes exactly 1 cycle after the AW handshake.
  - AW and W in the same cycle -> BVALID the next cycle.
- Backpressure:
  - BREADY low for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout.
  - RREADY low for 5 cycles -> RVALID/RDATA stable.
- Out of range: write 0xDEADBEEF to 0x18 -> BRESP=SLVERR, regs unchanged; read 0x18 -> RDATA=0, RRESP=SLVERR.
- Reset and feature:
  - Assert ARESET while BVALID=1 -> BVALID=0 and all regs=0 asynchronously, all READYs=1 after release.
  - With AXIL_REG_SLAVE_WR_COUNT_EN, after 4 OKAY writes, a read of 0x10 returns 4.
